// File: rtl/spi_pkg.sv
// Shared encodings and defaults for the SPI word-exchange engine.
package spi_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DIV_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    // cpha values, named after the sampling edge they select when cpol=0.
    localparam logic EDGE_POS = 1'b0;
    localparam logic EDGE_NEG = 1'b1;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every (clk_div+1) enabled cycles and flags each
// toggle as leading (away from cpol) or trailing (back to cpol).
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             en_i,
    input  logic             cpol_i,
    input  logic [DIV_W-1:0] clk_div_i,
    output logic             sclk_o,
    output logic             tick_o,
    output logic             lead_o,
    output logic             trail_o
);

    logic [DIV_W-1:0] div_cnt_q;
    logic             sclk_q;

    assign tick_o  = en_i && (div_cnt_q == clk_div_i);
    assign lead_o  = tick_o && (sclk_q == cpol_i);
    assign trail_o = tick_o && (sclk_q != cpol_i);
    assign sclk_o  = sclk_q;

    // While disabled the clock parks at cpol so the first toggle is a leading edge.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else if (!en_i) begin
            div_cnt_q <= '0;
            sclk_q    <= cpol_i;
        end else if (tick_o) begin
            div_cnt_q <= '0;
            sclk_q    <= ~sclk_q;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_xfer_engine.sv
// Single-word SPI master exchange: latches the mode/length/word on start,
// shifts N bits out on mosi while sampling miso, then pulses done for one cycle.
module spi_xfer_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              miso_i,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        state_o
);

    localparam logic [LEN_W-1:0] N_MAX = LEN_W'(DATA_W);

    state_e              state_q, state_d;
    logic                cpol_q, cpha_q, lsb_q;
    logic [DIV_W-1:0]    div_q;
    logic [LEN_W-1:0]    n_q, n_eff;
    logic [DATA_W-1:0]   tx_sr_q, rx_sr_q, data_q, rx_aligned;
    logic [LEN_W:0]      edge_cnt_q, two_n_m1;
    logic                last_q, out_valid_q;
    logic                gen_en, gen_cpol, tick, lead, trail;
    logic                shift_tx, sample_rx, tx_bit;

    assign n_eff    = (len_i == '0 || int'(len_i) > DATA_W) ? N_MAX : len_i;
    assign two_n_m1 = {n_q, 1'b0} - 1'b1;

    // The divider is held off for the final cycle so DONE follows the last toggle.
    assign gen_en   = (state_q == ST_XFER) && !last_q;
    assign gen_cpol = (state_q == ST_IDLE) ? cpol_i : cpol_q;

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .en_i      (gen_en),
        .cpol_i    (gen_cpol),
        .clk_div_i (div_q),
        .sclk_o    (sclk_o),
        .tick_o    (tick),
        .lead_o    (lead),
        .trail_o   (trail)
    );

    // With cpha=1 the first leading edge only exposes bit 0; later ones advance.
    assign shift_tx  = (cpha_q == EDGE_NEG) ? (lead && out_valid_q) : trail;
    assign sample_rx = (cpha_q == EDGE_NEG) ? trail : lead;
    assign tx_bit    = (lsb_q == LSB_FIRST) ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
    assign rx_aligned = (lsb_q == LSB_FIRST) ? (rx_sr_q >> (N_MAX - n_q)) : rx_sr_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_XFER;
            ST_XFER: if (last_q)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            div_q       <= '0;
            n_q         <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            data_q      <= '0;
            edge_cnt_q  <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    cpol_q <= cpol_i;
                    if (start_i) begin
                        cpha_q      <= cpha_i;
                        lsb_q       <= lsb_first_i;
                        div_q       <= clk_div_i;
                        n_q         <= n_eff;
                        tx_sr_q     <= (lsb_first_i == LSB_FIRST) ? data_i
                                                                  : (data_i << (N_MAX - n_eff));
                        rx_sr_q     <= '0;
                        edge_cnt_q  <= '0;
                        last_q      <= 1'b0;
                        out_valid_q <= (cpha_i == EDGE_POS);
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        if (edge_cnt_q == two_n_m1) begin
                            edge_cnt_q <= '0;
                            last_q     <= 1'b1;
                        end else begin
                            edge_cnt_q <= edge_cnt_q + 1'b1;
                        end
                    end
                    if (shift_tx) begin
                        tx_sr_q <= (lsb_q == LSB_FIRST) ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                    end
                    if (lead && cpha_q == EDGE_NEG) out_valid_q <= 1'b1;
                    if (sample_rx) begin
                        rx_sr_q <= (lsb_q == LSB_FIRST) ? {miso_i, rx_sr_q[DATA_W-1:1]}
                                                        : {rx_sr_q[DATA_W-2:0], miso_i};
                    end
                    if (last_q) data_q <= rx_aligned;
                end
                default: begin
                    last_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mosi_o  = (state_q == ST_XFER && out_valid_q) ? tx_bit : 1'b1;
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign data_o  = data_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: timing, bit order, modes, length clamp,
// start filtering, abort by reset and back-to-back words.
module tb_spi_xfer_engine;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
  localparam int LEN_W  = 4;

  logic              clk;
  logic              srst_i, start_i, cpol_i, cpha_i, lsb_first_i;
  logic [DIV_W-1:0]  clk_div_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] data_i;
  logic              miso_i;
  logic              sclk_o, mosi_o, busy_o, done_o;
  logic [DATA_W-1:0] data_o;
  logic [1:0]        state_o;
  logic              loop_en, miso_fix;

  int                vectors = 0;
  int                miscompares = 0;
  int                cyc, tog, dn;
  logic [31:0]       seq;
  int                dc [3];
  logic              prev_done;

  assign miso_i = loop_en ? mosi_o : miso_fix;

  spi_xfer_engine #(.DATA_W(DATA_W), .DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .clk_i       (clk),
    .srst_i      (srst_i),
    .start_i     (start_i),
    .cpol_i      (cpol_i),
    .cpha_i      (cpha_i),
    .lsb_first_i (lsb_first_i),
    .clk_div_i   (clk_div_i),
    .len_i       (len_i),
    .data_i      (data_i),
    .miso_i      (miso_i),
    .sclk_o      (sclk_o),
    .mosi_o      (mosi_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .data_o      (data_o),
    .state_o     (state_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then follows the word to done_o, counting
  // cycles from the start cycle, SCLK toggles, and the mosi bits a slave
  // would capture on its sampling edges.
  task automatic run_word(input int disturb_at);
    logic ps, pm, cp, ch;
    cp = cpol_i;
    ch = cpha_i;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 1;
    tog = 0;
    seq = '0;
    while (done_o !== 1'b1 && cyc < 2000) begin
      ps = sclk_o;
      pm = mosi_o;
      tick();
      cyc++;
      if (cyc == disturb_at) begin
        start_i = 1'b1;
        cpol_i  = ~cpol_i;
      end else if (cyc == disturb_at + 1) begin
        start_i = 1'b0;
      end
      if (sclk_o !== ps) begin
        tog++;
        if ((ps === cp) != ch) seq = {seq[30:0], pm};
      end
    end
    check("done_seen", {31'd0, done_o}, 32'd1);
  endtask

  initial begin
    srst_i = 1'b1; start_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0;
    clk_div_i = '0; len_i = 4'd8; data_i = '0; loop_en = 1'b0; miso_fix = 1'b0;
    tick();
    tick();
    check("rst_sclk", {31'd0, sclk_o}, 32'd0);
    check("rst_mosi", {31'd0, mosi_o}, 32'd1);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    check("rst_state", {30'd0, state_o}, 32'd0);
    srst_i = 1'b0;
    tick();

    // mode 0, MSB first, div 0, loopback 0xA5
    data_i = 8'hA5; loop_en = 1'b1;
    tick();
    run_word(0);
    check("m0_cycles", cyc, 18);
    check("m0_toggles", tog, 16);
    check("m0_mosi_seq", seq, 32'hA5);
    check("m0_data", {24'd0, data_o}, 32'hA5);
    tick();
    check("m0_done_single", {31'd0, done_o}, 32'd0);
    check("m0_idle_busy", {31'd0, busy_o}, 32'd0);
    check("m0_idle_mosi", {31'd0, mosi_o}, 32'd1);

    // mode 3, LSB first, div 3, miso tied high
    cpol_i = 1'b1; cpha_i = 1'b1; lsb_first_i = 1'b1; clk_div_i = 8'd3;
    data_i = 8'h3C; loop_en = 1'b0; miso_fix = 1'b1;
    tick();
    tick();
    check("m3_sclk_idle_pre", {31'd0, sclk_o}, 32'd1);
    run_word(0);
    check("m3_cycles", cyc, 66);
    check("m3_toggles", tog, 16);
    check("m3_mosi_seq", seq, 32'h3C);
    check("m3_data", {24'd0, data_o}, 32'hFF);
    tick();
    check("m3_sclk_idle_post", {31'd0, sclk_o}, 32'd1);

    // mode 1, len 0 and len 12 both clamp to 8 bits
    cpol_i = 1'b0; cpha_i = 1'b1; lsb_first_i = 1'b0; clk_div_i = 8'd0;
    data_i = 8'h81; loop_en = 1'b1; len_i = 4'd0;
    tick();
    tick();
    run_word(0);
    check("len0_cycles", cyc, 18);
    check("len0_toggles", tog, 16);
    check("len0_data", {24'd0, data_o}, 32'h81);
    len_i = 4'd12;
    tick();
    run_word(0);
    check("len12_cycles", cyc, 18);
    check("len12_toggles", tog, 16);
    check("len12_mosi_seq", seq, 32'h81);
    check("len12_data", {24'd0, data_o}, 32'h81);

    // start pulse and cpol flip in mid-word are ignored
    cpha_i = 1'b0; clk_div_i = 8'd1; len_i = 4'd8; data_i = 8'h5A;
    tick();
    tick();
    run_word(5);
    check("dist_cycles", cyc, 34);
    check("dist_toggles", tog, 16);
    check("dist_mosi_seq", seq, 32'h5A);
    check("dist_data", {24'd0, data_o}, 32'h5A);
    tick();
    check("dist_done_single", {31'd0, done_o}, 32'd0);
    tick();
    check("dist_no_restart", {31'd0, busy_o}, 32'd0);
    cpol_i = 1'b0;
    tick();

    // reset at the 5th SCLK toggle aborts the word
    cpol_i = 1'b1; data_i = 8'h33;
    tick();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tog = 0;
    for (int k = 0; k < 200 && tog < 5; k++) begin
      logic ps;
      ps = sclk_o;
      tick();
      if (sclk_o !== ps) tog++;
    end
    check("abort_reached_5", tog, 5);
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_sclk", {31'd0, sclk_o}, 32'd0);
    check("abort_mosi", {31'd0, mosi_o}, 32'd1);
    check("abort_data", {24'd0, data_o}, 32'd0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      if (done_o === 1'b1) dn++;
      tick();
    end
    check("abort_no_done", dn, 0);

    // reset wins over start in the same cycle
    cpol_i = 1'b0;
    srst_i = 1'b1; start_i = 1'b1;
    tick();
    srst_i = 1'b0; start_i = 1'b0;
    check("rst_over_start", {31'd0, busy_o}, 32'd0);
    tick();

    // start held high: three 4-bit words, one idle cycle between them
    cpha_i = 1'b0; lsb_first_i = 1'b0; clk_div_i = 8'd1; len_i = 4'd4;
    data_i = 8'h0A; loop_en = 1'b1;
    tick();
    start_i = 1'b1;
    dn = 0;
    prev_done = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (prev_done) check("hold_idle_gap", {31'd0, busy_o}, 32'd0);
      prev_done = done_o;
      if (done_o === 1'b1) begin
        if (dn < 3) dc[dn] = c;
        dn++;
        if (dn == 3) start_i = 1'b0;
      end
    end
    check("hold_done_count", dn, 3);
    check("hold_done0_cycle", dc[0], 18);
    check("hold_done1_cycle", dc[1], 37);
    check("hold_done2_cycle", dc[2], 56);
    check("hold_data", {24'd0, data_o}, 32'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
